reg_bridge: RTL and testbench

REG_BRIDGE -- requirements
Module: reg_bridge

---
 rtl/reg_bridge_pkg.sv | 26 ++
 rtl/reg_bridge.sv | 133 +++++++++++++
 tb/tb_reg_bridge.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bridge_pkg.sv
// Shared constants for the byte-stream to register-port bridge:
// FSM encoding, response status codes and command byte fields.
package reg_bridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [7:0] STAT_OK  = 8'h00;
  localparam logic [7:0] STAT_ERR = 8'h01;
  localparam logic [7:0] STAT_TMO = 8'h02;
  localparam logic [7:0] STAT_BAD = 8'h03;

  localparam int CMD_WR     = 7;
  localparam int CMD_RSV_HI = 6;
  localparam int CMD_RSV_LO = 4;
  localparam int CMD_AHI_HI = 3;

  function automatic logic cmd_bad(input logic [7:0] c);
    return |c[CMD_RSV_HI:CMD_RSV_LO];
  endfunction

endpackage

// File: rtl/reg_bridge.sv
// Host byte-stream to register-port bridge: parses CMD/ADDR/WDATA
// frames, issues one register request, returns a status/data response.
module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic        rxready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  input  logic        txready,
  output logic        regreq,
  output logic        regwr,
  output logic [11:0] regaddr,
  output logic [31:0] regwdata,
  input  logic        regack,
  input  logic        regerr,
  input  logic [31:0] regrdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic          up;
  logic          wr;
  logic [11:0]   addr;
  logic [31:0]   wsh;
  logic [31:0]   rsh;
  logic [7:0]    status;
  logic [1:0]    bcnt;
  logic [2:0]    tcnt;
  logic          first;
  logic [CW-1:0] cnt;
  logic          rx_fire;
  logic          tx_fire;

  // up holds rxready low for the first cycle after reset release
  assign rxready = up & ((state == ST_IDLE) |
                         (state == ST_ADDR) |
                         (state == ST_WDATA));
  assign txvalid  = (state == ST_RESP);
  assign txdata   = first ? status : rsh[7:0];
  assign regreq   = (state == ST_REQ);
  assign regwr    = wr;
  assign regaddr  = addr;
  assign regwdata = wsh;

  assign rx_fire = rxvalid & rxready;
  assign tx_fire = txvalid & txready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      up     <= 1'b0;
      wr     <= 1'b0;
      addr   <= '0;
      wsh    <= '0;
      rsh    <= '0;
      status <= '0;
      bcnt   <= '0;
      tcnt   <= '0;
      first  <= 1'b0;
      cnt    <= '0;
    end else begin
      up <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            if (cmd_bad(rxdata)) begin
              status <= STAT_BAD;
              tcnt   <= 3'd1;
              first  <= 1'b1;
              state  <= ST_RESP;
            end else begin
              wr          <= rxdata[CMD_WR];
              addr[11:8]  <= rxdata[CMD_AHI_HI:0];
              state       <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            addr[7:0] <= rxdata;
            bcnt      <= '0;
            state     <= wr ? ST_WDATA : ST_REQ;
          end
        end
        ST_WDATA: begin
          if (rx_fire) begin
            wsh  <= {rxdata, wsh[31:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // ack is checked first so it wins on the timeout cycle
          if (regack) begin
            status <= regerr ? STAT_ERR : STAT_OK;
            rsh    <= regrdata;
            tcnt   <= (!wr && !regerr) ? 3'd5 : 3'd1;
            first  <= 1'b1;
            state  <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            status <= STAT_TMO;
            tcnt   <= 3'd1;
            first  <= 1'b1;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (tx_fire) begin
            first <= 1'b0;
            if (!first) rsh <= {8'h00, rsh[31:8]};
            tcnt <= tcnt - 3'd1;
            if (tcnt == 3'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bridge.sv
// Directed bench for reg_bridge: default-timeout and TIMEOUT=16
// instances, table vectors plus timeout/reset/backpressure sequences.
module tb_reg_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rxdata = '0;
  logic        rxvalid = 1'b0;
  logic        txready = 1'b0;
  logic        regack = 1'b0;
  logic        regerr = 1'b0;
  logic [31:0] regrdata = '0;
  logic        sel = 1'b0;

  logic        rxready_a, txvalid_a, regreq_a, regwr_a;
  logic [7:0]  txdata_a;
  logic [11:0] regaddr_a;
  logic [31:0] regwdata_a;
  logic        rxready_b, txvalid_b, regreq_b, regwr_b;
  logic [7:0]  txdata_b;
  logic [11:0] regaddr_b;
  logic [31:0] regwdata_b;

  logic        rxready_m, txvalid_m, regreq_m, regwr_m;
  logic [7:0]  txdata_m;
  logic [11:0] regaddr_m;
  logic [31:0] regwdata_m;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  reg_bridge u_a (
    .clk(clk), .rstn(rstn),
    .rxdata(rxdata), .rxvalid(rxvalid & ~sel), .rxready(rxready_a),
    .txdata(txdata_a), .txvalid(txvalid_a), .txready(txready & ~sel),
    .regreq(regreq_a), .regwr(regwr_a), .regaddr(regaddr_a),
    .regwdata(regwdata_a), .regack(regack & ~sel), .regerr(regerr),
    .regrdata(regrdata)
  );

  reg_bridge #(.TIMEOUT(16)) u_b (
    .clk(clk), .rstn(rstn),
    .rxdata(rxdata), .rxvalid(rxvalid & sel), .rxready(rxready_b),
    .txdata(txdata_b), .txvalid(txvalid_b), .txready(txready & sel),
    .regreq(regreq_b), .regwr(regwr_b), .regaddr(regaddr_b),
    .regwdata(regwdata_b), .regack(regack & sel), .regerr(regerr),
    .regrdata(regrdata)
  );

  assign rxready_m  = sel ? rxready_b  : rxready_a;
  assign txvalid_m  = sel ? txvalid_b  : txvalid_a;
  assign txdata_m   = sel ? txdata_b   : txdata_a;
  assign regreq_m   = sel ? regreq_b   : regreq_a;
  assign regwr_m    = sel ? regwr_b    : regwr_a;
  assign regaddr_m  = sel ? regaddr_b  : regaddr_a;
  assign regwdata_m = sel ? regwdata_b : regwdata_a;

  always @(posedge clk)
    if (regreq_a | regreq_b) req_cnt <= req_cnt + 1;

  typedef struct {
    logic        sel;
    int          nrx;
    logic [47:0] rx;
    logic        req;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic        err;
    logic [31:0] rdata;
    int          ntx;
    logic [39:0] tx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rxdata  = b;
    rxvalid = 1'b1;
    while (!rxready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", {63'd0, rxready_m}, 64'd1);
    @(negedge clk);
    rxvalid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!regreq_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("regreq_seen", {63'd0, regreq_m}, 64'd1);
  endtask

  task automatic recv_byte(input logic [7:0] e, input string nm);
    int n = 0;
    while (!txvalid_m && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, {63'd0, txvalid_m}, 64'd1);
    chk(nm, {56'd0, txdata_m}, {56'd0, e});
    txready = 1'b1;
    @(negedge clk);
    txready = 1'b0;
  endtask

  task automatic pulse_ack(input logic e, input logic [31:0] d);
    regack   = 1'b1;
    regerr   = e;
    regrdata = d;
    @(negedge clk);
    regack   = 1'b0;
    regerr   = 1'b0;
  endtask

  initial begin
    int rc0;
    int n;
    logic bad;
    vec_t v;

    vecs[0] = '{sel:0, nrx:6, rx:48'h00_00_00_01_00_80, req:1, wr:1,
                addr:12'h000, wdata:32'h0000_0001, dly:3, err:0,
                rdata:32'h0, ntx:1, tx:40'h00};
    vecs[1] = '{sel:0, nrx:2, rx:48'h04_00, req:1, wr:0,
                addr:12'h004, wdata:32'h0, dly:2, err:0,
                rdata:32'h0000_0400, ntx:5, tx:40'h00_00_04_00_00};
    vecs[2] = '{sel:0, nrx:2, rx:48'h08_00, req:1, wr:0,
                addr:12'h008, wdata:32'h0, dly:200, err:0,
                rdata:32'hDEAD_BEEF, ntx:5, tx:40'hDE_AD_BE_EF_00};
    vecs[3] = '{sel:1, nrx:2, rx:48'h1C_00, req:1, wr:0,
                addr:12'h01C, wdata:32'h0, dly:2, err:1,
                rdata:32'h5555_5555, ntx:1, tx:40'h01};
    vecs[4] = '{sel:0, nrx:1, rx:48'h70, req:0, wr:0,
                addr:12'h0, wdata:32'h0, dly:1, err:0,
                rdata:32'h0, ntx:1, tx:40'h03};
    vecs[5] = '{sel:0, nrx:6, rx:48'h12_34_56_78_BC_8A, req:1, wr:1,
                addr:12'hABC, wdata:32'h1234_5678, dly:1, err:0,
                rdata:32'hFFFF_FFFF, ntx:1, tx:40'h00};
    vecs[6] = '{sel:1, nrx:2, rx:48'hFF_0F, req:1, wr:0,
                addr:12'hFFF, wdata:32'h0, dly:1, err:0,
                rdata:32'hCAFE_F00D, ntx:5, tx:40'hCA_FE_F0_0D_00};
    vecs[7] = '{sel:1, nrx:2, rx:48'h30_00, req:1, wr:0,
                addr:12'h030, wdata:32'h0, dly:17, err:0,
                rdata:32'h0000_00A5, ntx:5, tx:40'h00_00_00_A5_00};

    repeat (3) @(negedge clk);
    chk("rst_rxready", {62'd0, rxready_a, rxready_b}, 64'd0);
    chk("rst_txvalid", {62'd0, txvalid_a, txvalid_b}, 64'd0);
    chk("rst_regreq", {62'd0, regreq_a, regreq_b}, 64'd0);
    chk("rst_regbus", {19'd0, regwr_a, regaddr_a, regwdata_a}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rxready_rise", {63'd0, rxready_a}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      v   = vecs[i];
      sel = v.sel;
      rc0 = req_cnt;
      for (int j = 0; j < v.nrx; j++) send_byte(v.rx[8*j +: 8]);
      if (v.req) begin
        wait_req();
        chk($sformatf("v%0d_regwr", i), {63'd0, regwr_m}, {63'd0, v.wr});
        chk($sformatf("v%0d_regaddr", i), {52'd0, regaddr_m},
            {52'd0, v.addr});
        if (v.wr)
          chk($sformatf("v%0d_regwdata", i), {32'd0, regwdata_m},
              {32'd0, v.wdata});
        @(negedge clk);
        chk($sformatf("v%0d_req_1cyc", i), {63'd0, regreq_m}, 64'd0);
        repeat (v.dly - 1) @(negedge clk);
        pulse_ack(v.err, v.rdata);
      end
      for (int j = 0; j < v.ntx; j++)
        recv_byte(v.tx[8*j +: 8], $sformatf("v%0d_tx%0d", i, j));
      if (!v.req)
        chk($sformatf("v%0d_no_req", i), 64'(req_cnt), 64'(rc0));
      chk($sformatf("v%0d_idle", i), {62'd0, txvalid_m, rxready_m},
          64'd1);
    end

    // timeout on the TIMEOUT=16 instance, then a late ack
    sel = 1'b1;
    send_byte(8'h00);
    send_byte(8'h20);
    wait_req();
    n = 0;
    while (!txvalid_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency_ok", {63'd0, (n >= 16 && n <= 19)}, 64'd1);
    recv_byte(8'h02, "tmo_status");
    pulse_ack(1'b0, 32'h1234_5678);
    bad = 1'b0;
    repeat (5) begin
      if (txvalid_m || !rxready_m) bad = 1'b1;
      @(negedge clk);
    end
    chk("tmo_late_ack_ignored", {63'd0, bad}, 64'd0);
    send_byte(8'h40);
    recv_byte(8'h03, "tmo_after_badcmd");

    // reset in WAIT drops the frame
    sel = 1'b0;
    send_byte(8'h00);
    send_byte(8'h10);
    wait_req();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", {61'd0, rxready_a, txvalid_a, regreq_a}, 64'd0);
    chk("mid_rst_addr", {52'd0, regaddr_a}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_rxready", {63'd0, rxready_a}, 64'd1);
    pulse_ack(1'b0, 32'hAAAA_AAAA);
    bad = 1'b0;
    repeat (5) begin
      if (txvalid_a) bad = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_resp", {63'd0, bad}, 64'd0);

    // backpressure: response byte held for 10 cycles
    send_byte(8'h00);
    send_byte(8'h04);
    wait_req();
    @(negedge clk);
    pulse_ack(1'b0, 32'h1122_3344);
    n = 0;
    while (!txvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
    repeat (10) begin
      if (!txvalid_m || txdata_m !== 8'h00) bad = 1'b1;
      @(negedge clk);
    end
    chk("bp_stable", {63'd0, bad}, 64'd0);
    recv_byte(8'h00, "bp_tx0");
    recv_byte(8'h44, "bp_tx1");
    recv_byte(8'h33, "bp_tx2");
    recv_byte(8'h22, "bp_tx3");
    recv_byte(8'h11, "bp_tx4");
    chk("bp_idle", {62'd0, txvalid_m, rxready_m}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
